// File: rtl/pcie_pio_responder.sv
// rtl/pcie_pio_responder.sv - single-DW PIO target: MRd32/MWr32 to a 4-register file, CplD on TX
module pcie_pio_responder #(
    parameter logic [31:0] ID_VALUE = 32'h4B433730
) (
    input  logic        USER_CLK,
    input  logic        USER_RST_B,
    input  logic [15:0] CFG_COMPLETER_ID,
    input  logic [63:0] RX_TDATA,
    input  logic [7:0]  RX_TKEEP,
    input  logic        RX_TVALID,
    input  logic        RX_TLAST,
    output logic        RX_TREADY,
    output logic [63:0] TX_TDATA,
    output logic [7:0]  TX_TKEEP,
    output logic        TX_TVALID,
    output logic        TX_TLAST,
    input  logic        TX_TREADY,
    output logic [3:0]  GPIO_LED
);

    typedef enum logic [2:0] {IDLE, HDR2, DRAIN, CPL0, CPL1} state_t;

    state_t      state, state_nx;
    logic        rx_en;
    logic [31:0] led_reg, scratch_reg, counter, rd_data, rd_mux;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  first_be;
    logic        is_wr;
    logic [6:0]  lower_addr;
    logic        rx_fire, hdr_ok, wr_en, rd_en;
    logic [31:0] cpl_dw0, cpl_dw1, cpl_dw2;
    logic        unused_ok;

    assign rx_fire = RX_TVALID && RX_TREADY;
    assign hdr_ok  = (RX_TDATA[30:29] == 2'b00 || RX_TDATA[30:29] == 2'b10)
                     && RX_TDATA[28:24] == 5'b00000 && RX_TDATA[9:0] == 10'd1;
    assign wr_en   = (state == HDR2) && rx_fire && RX_TLAST && is_wr;
    assign rd_en   = (state == HDR2) && rx_fire && RX_TLAST && !is_wr;
    assign unused_ok = &{1'b0, RX_TKEEP, RX_TDATA};

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    always_comb begin
        rd_mux = 32'h0;
        case (RX_TDATA[3:2])
            2'd0: rd_mux = led_reg;
            2'd1: rd_mux = scratch_reg;
            2'd2: rd_mux = counter;
            2'd3: rd_mux = ID_VALUE;
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (rx_fire) state_nx = RX_TLAST ? IDLE : (hdr_ok ? HDR2 : DRAIN);
            HDR2:  if (rx_fire) state_nx = !RX_TLAST ? DRAIN : (is_wr ? IDLE : CPL0);
            DRAIN: if (rx_fire && RX_TLAST) state_nx = IDLE;
            CPL0:  if (TX_TREADY) state_nx = CPL1;
            CPL1:  if (TX_TREADY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge USER_CLK or negedge USER_RST_B) begin
        if (!USER_RST_B) begin
            state <= IDLE;
            rx_en <= 1'b0;
        end else begin
            state <= state_nx;
            rx_en <= 1'b1;
        end
    end

    always_ff @(posedge USER_CLK or negedge USER_RST_B) begin
        if (!USER_RST_B) begin
            tc         <= 3'd0;
            attr       <= 2'd0;
            req_id     <= 16'h0;
            tag        <= 8'h0;
            first_be   <= 4'h0;
            is_wr      <= 1'b0;
            lower_addr <= 7'h0;
            rd_data    <= 32'h0;
        end else begin
            if (state == IDLE && rx_fire) begin
                tc       <= RX_TDATA[22:20];
                attr     <= RX_TDATA[13:12];
                is_wr    <= RX_TDATA[30];
                req_id   <= RX_TDATA[63:48];
                tag      <= RX_TDATA[47:40];
                first_be <= RX_TDATA[35:32];
            end
            if (rd_en) begin
                lower_addr <= {RX_TDATA[6:2], 2'b00};
                rd_data    <= rd_mux;
            end
        end
    end

    // Register file; counter runs every cycle and wraps naturally.
    always_ff @(posedge USER_CLK or negedge USER_RST_B) begin
        if (!USER_RST_B) begin
            led_reg     <= 32'h0;
            scratch_reg <= 32'h0;
            counter     <= 32'h0;
            GPIO_LED    <= 4'h0;
        end else begin
            counter  <= counter + 32'd1;
            GPIO_LED <= led_reg[3:0];
            if (wr_en) begin
                if (RX_TDATA[3:2] == 2'd0)
                    led_reg <= merge(led_reg, RX_TDATA[63:32], first_be);
                if (RX_TDATA[3:2] == 2'd1)
                    scratch_reg <= merge(scratch_reg, RX_TDATA[63:32], first_be);
            end
        end
    end

    assign cpl_dw0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc, 6'b0, attr, 2'b0, 10'd1};
    assign cpl_dw1 = {CFG_COMPLETER_ID, 3'b000, 1'b0, 12'd4};
    assign cpl_dw2 = {req_id, tag, 1'b0, lower_addr};

    assign RX_TREADY = rx_en && (state == IDLE || state == HDR2 || state == DRAIN);
    assign TX_TVALID = (state == CPL0) || (state == CPL1);
    assign TX_TLAST  = (state == CPL1);
    assign TX_TKEEP  = TX_TVALID ? 8'hFF : 8'h00;
    assign TX_TDATA  = (state == CPL0) ? {cpl_dw1, cpl_dw0} :
                       (state == CPL1) ? {rd_data, cpl_dw2} : 64'h0;

endmodule
